// File: rtl/vram_arb_pkg.sv
// vram_arb_pkg: state encoding, requester selects and parameter checks shared by the vram_arbiter slice
package vram_arb_pkg;
  typedef enum logic [1:0] {IDLE, CPU_ACC, VID_ACC, RECOVER} state_t;
  typedef enum logic {SEL_CPU, SEL_VID} sel_t;
  function automatic bit acc_cyc_ok(input int n);
    return n >= 1;
  endfunction
endpackage

// File: rtl/vram_arb_guard.sv
// vram_arb_guard: counts video grants taken over a pending CPU and forces a CPU grant at MAX_WAIT (used with VRAM_ARB_STARVE_EN)
module vram_arb_guard
#(
  parameter int MAX_WAIT = 8
)(
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic idle,
  input  logic cpu_req,
  input  logic vid_grant,
  input  logic cpu_grant,
  output logic force_cpu
);
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] LIMIT = WW'(MAX_WAIT);
  logic [WW-1:0] wait_cnt;
  // clear when the CPU is served or gives up, otherwise count video grants that bypass it
  always_ff @(posedge sys_clk)
    if (sys_rst || cpu_grant || (idle && !cpu_req)) wait_cnt <= '0;
    else if (vid_grant && cpu_req && wait_cnt != LIMIT) wait_cnt <= wait_cnt + 1'b1;
  assign force_cpu = wait_cnt == LIMIT;
endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: sequences the shared SRAM between CPU and video ports; VRAM_ARB_STARVE_EN adds the CPU starvation guard
module vram_arbiter
  import vram_arb_pkg::*;
#(
  parameter int AW       = 15,
  parameter int DW       = 8,
  parameter int ACC_CYC  = 2,
  parameter int MAX_WAIT = 8
)(
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,
  output logic          cpu_rdy,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic [DW-1:0] vid_rdata,
  output logic          vid_ack,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_drive,
  input  logic [DW-1:0] mem_rdata,
  output logic          mem_cs_n,
  output logic          mem_oe_n,
  output logic          mem_we_n,
  output logic          busy
);
  localparam int CW = $clog2(ACC_CYC + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(ACC_CYC - 1);
  if (!acc_cyc_ok(ACC_CYC)) begin : g_bad_acc
    $error("vram_arbiter: ACC_CYC must be >= 1");
  end
  if (MAX_WAIT < 1) begin : g_bad_wait
    $error("vram_arbiter: MAX_WAIT must be >= 1");
  end
  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          wr, wr_n;
  sel_t          sel;
  logic          grant, last, acc_n, we_strobe, force_cpu;
`ifdef VRAM_ARB_STARVE_EN
  vram_arb_guard #(.MAX_WAIT(MAX_WAIT)) u_guard (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .idle      (state == IDLE),
    .cpu_req   (cpu_req),
    .vid_grant (grant && sel == SEL_VID),
    .cpu_grant (grant && sel == SEL_CPU),
    .force_cpu (force_cpu)
  );
`else
  assign force_cpu = 1'b0;
`endif
  assign busy    = state != IDLE;
  assign cpu_rdy = !cpu_req || cpu_ack;
  // next state, grant decision and the strobe pattern for the cycle after this edge
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    wr_n    = wr;
    sel     = SEL_CPU;
    grant   = 1'b0;
    last    = (state == CPU_ACC || state == VID_ACC) && cnt == '0;
    case (state)
      IDLE:
        if (vid_req && !force_cpu) begin
          state_n = VID_ACC;
          sel     = SEL_VID;
          wr_n    = 1'b0;
          cnt_n   = CNT_LOAD;
          grant   = 1'b1;
        end else if (cpu_req) begin
          state_n = CPU_ACC;
          wr_n    = cpu_we;
          cnt_n   = CNT_LOAD;
          grant   = 1'b1;
        end
      CPU_ACC, VID_ACC:
        if (cnt == '0) state_n = RECOVER;
        else cnt_n = cnt - 1'b1;
      default: state_n = IDLE;
    endcase
    acc_n     = state_n == CPU_ACC || state_n == VID_ACC;
    we_strobe = acc_n && wr_n && (ACC_CYC == 1 || cnt_n != CNT_LOAD);
  end
  // sequencer state and registered SRAM strobes so the pins change cleanly on the clock
  always_ff @(posedge sys_clk)
    if (sys_rst) begin
      state     <= IDLE;
      cnt       <= '0;
      wr        <= 1'b0;
      mem_cs_n  <= 1'b1;
      mem_oe_n  <= 1'b1;
      mem_we_n  <= 1'b1;
      mem_drive <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      wr        <= wr_n;
      mem_cs_n  <= !acc_n;
      mem_oe_n  <= !(acc_n && !wr_n);
      mem_we_n  <= !we_strobe;
      mem_drive <= acc_n && wr_n;
    end
  // address/data latching at grant, read capture on the last access cycle, ack in RECOVER
  always_ff @(posedge sys_clk)
    if (sys_rst) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_rdata <= '0;
      vid_rdata <= '0;
      cpu_ack   <= 1'b0;
      vid_ack   <= 1'b0;
    end else begin
      if (grant) mem_addr <= sel == SEL_VID ? vid_addr : cpu_addr;
      if (grant && sel == SEL_CPU && cpu_we) mem_wdata <= cpu_wdata;
      if (last && state == CPU_ACC && !wr) cpu_rdata <= mem_rdata;
      if (last && state == VID_ACC) vid_rdata <= mem_rdata;
      cpu_ack <= last && state == CPU_ACC;
      vid_ack <= last && state == VID_ACC;
    end
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed checks of vram_arbiter timing, priority, reset abort and starvation behaviour
module tb_vram_arbiter;
  localparam int AW = 15;
  localparam int DW = 8;
  logic          sys_clk = 1'b0;
  logic          sys_rst = 1'b1;
  logic          cpu_req = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0, vid_addr = '0;
  logic [DW-1:0] cpu_wdata = '0, mem_rdata = '0;
  logic          vid_req = 1'b0;
  logic [DW-1:0] cpu_rdata, vid_rdata, mem_wdata;
  logic          cpu_ack, cpu_rdy, vid_ack, mem_drive, mem_cs_n, mem_oe_n, mem_we_n, busy;
  logic [AW-1:0] mem_addr;
  int checks = 0, errors = 0;
  int va, ca, vbefore, cfirst;
  vram_arbiter #(.AW(AW), .DW(DW), .ACC_CYC(2), .MAX_WAIT(8)) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ack   (cpu_ack),
    .cpu_rdy   (cpu_rdy),
    .vid_req   (vid_req),
    .vid_addr  (vid_addr),
    .vid_rdata (vid_rdata),
    .vid_ack   (vid_ack),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_drive (mem_drive),
    .mem_rdata (mem_rdata),
    .mem_cs_n  (mem_cs_n),
    .mem_oe_n  (mem_oe_n),
    .mem_we_n  (mem_we_n),
    .busy      (busy)
  );
  always #5 sys_clk = ~sys_clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge sys_clk);
    #1;
  endtask
  task automatic smp;
    @(negedge sys_clk);
  endtask
  initial begin
    step;
    step;
    sys_rst = 1'b0;
    smp;
    chk("rst_cs_n", 32'(mem_cs_n), 32'h1);
    chk("rst_oe_n", 32'(mem_oe_n), 32'h1);
    chk("rst_we_n", 32'(mem_we_n), 32'h1);
    chk("rst_drive", 32'(mem_drive), 32'h0);
    chk("rst_addr", 32'(mem_addr), 32'h0);
    chk("rst_wdata", 32'(mem_wdata), 32'h0);
    chk("rst_acks", 32'({cpu_ack, vid_ack}), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_rdy", 32'(cpu_rdy), 32'h1);
    // CPU read of 0x1234 returning 0xA5
    step;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h1234; mem_rdata = 8'hA5;
    smp;
    chk("rd_c0_rdy", 32'(cpu_rdy), 32'h0);
    chk("rd_c0_cs_n", 32'(mem_cs_n), 32'h1);
    step; smp;
    chk("rd_c1_cs_n", 32'(mem_cs_n), 32'h0);
    chk("rd_c1_oe_n", 32'(mem_oe_n), 32'h0);
    chk("rd_c1_addr", 32'(mem_addr), 32'h1234);
    chk("rd_c1_drive", 32'(mem_drive), 32'h0);
    chk("rd_c1_rdy", 32'(cpu_rdy), 32'h0);
    step; smp;
    chk("rd_c2_cs_oe", 32'({mem_cs_n, mem_oe_n, mem_we_n}), 32'h1);
    chk("rd_c2_rdy", 32'(cpu_rdy), 32'h0);
    step; smp;
    chk("rd_c3_ack", 32'(cpu_ack), 32'h1);
    chk("rd_c3_rdata", 32'(cpu_rdata), 32'hA5);
    chk("rd_c3_rdy", 32'(cpu_rdy), 32'h1);
    chk("rd_c3_strobes", 32'({mem_cs_n, mem_oe_n, mem_we_n}), 32'h7);
    step;
    cpu_req = 1'b0;
    smp;
    chk("rd_c4_ack", 32'(cpu_ack), 32'h0);
    chk("rd_c4_busy", 32'(busy), 32'h0);
    // CPU write of 0x5A to 0x0200
    step;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h0200; cpu_wdata = 8'h5A; mem_rdata = 8'hFF;
    smp;
    step; smp;
    chk("wr_c1_drive", 32'(mem_drive), 32'h1);
    chk("wr_c1_we_n", 32'(mem_we_n), 32'h1);
    chk("wr_c1_oe_n", 32'(mem_oe_n), 32'h1);
    chk("wr_c1_cs_n", 32'(mem_cs_n), 32'h0);
    chk("wr_c1_wdata", 32'(mem_wdata), 32'h5A);
    chk("wr_c1_addr", 32'(mem_addr), 32'h0200);
    step; smp;
    chk("wr_c2_drive", 32'(mem_drive), 32'h1);
    chk("wr_c2_we_n", 32'(mem_we_n), 32'h0);
    step; smp;
    chk("wr_c3_ack", 32'(cpu_ack), 32'h1);
    chk("wr_c3_we_n", 32'(mem_we_n), 32'h1);
    chk("wr_c3_drive", 32'(mem_drive), 32'h0);
    chk("wr_c3_rdata_held", 32'(cpu_rdata), 32'hA5);
    step;
    cpu_req = 1'b0; cpu_we = 1'b0;
    // simultaneous requests: video first, then CPU
    step;
    cpu_req = 1'b1; cpu_addr = 15'h0010; vid_req = 1'b1; vid_addr = 15'h0777; mem_rdata = 8'h3C;
    smp;
    step; smp;
    chk("both_c1_addr", 32'(mem_addr), 32'h0777);
    step; smp;
    step; smp;
    chk("both_c3_vid_ack", 32'(vid_ack), 32'h1);
    chk("both_c3_vid_rdata", 32'(vid_rdata), 32'h3C);
    chk("both_c3_cpu_ack", 32'(cpu_ack), 32'h0);
    step;
    vid_req = 1'b0; mem_rdata = 8'hC3;
    smp;
    chk("both_c4_busy", 32'(busy), 32'h0);
    chk("both_c4_vid_ack", 32'(vid_ack), 32'h0);
    step; smp;
    chk("both_c5_busy", 32'(busy), 32'h1);
    chk("both_c5_addr", 32'(mem_addr), 32'h0010);
    step; smp;
    chk("both_c6_cpu_ack", 32'(cpu_ack), 32'h0);
    step; smp;
    chk("both_c7_cpu_ack", 32'(cpu_ack), 32'h1);
    chk("both_c7_cpu_rdata", 32'(cpu_rdata), 32'hC3);
    chk("both_c7_vid_rdata", 32'(vid_rdata), 32'h3C);
    step;
    cpu_req = 1'b0;
    // reset in the second access cycle aborts the read; reissue completes
    step;
    cpu_req = 1'b1; cpu_addr = 15'h0055; mem_rdata = 8'h77;
    smp;
    step; smp;
    chk("abort_c1_cs_n", 32'(mem_cs_n), 32'h0);
    step;
    sys_rst = 1'b1;
    smp;
    step;
    sys_rst = 1'b0;
    smp;
    chk("abort_strobes", 32'({mem_cs_n, mem_oe_n, mem_we_n}), 32'h7);
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_ack", 32'(cpu_ack), 32'h0);
    chk("abort_rdata", 32'(cpu_rdata), 32'h0);
    chk("abort_rdy", 32'(cpu_rdy), 32'h0);
    step; smp;
    chk("reissue_busy", 32'(busy), 32'h1);
    chk("reissue_addr", 32'(mem_addr), 32'h0055);
    chk("reissue_c1_ack", 32'(cpu_ack), 32'h0);
    step; smp;
    step; smp;
    chk("reissue_ack", 32'(cpu_ack), 32'h1);
    chk("reissue_rdata", 32'(cpu_rdata), 32'h77);
    step;
    cpu_req = 1'b0;
    // both requests held high for 48 cycles
    step;
    cpu_req = 1'b1; cpu_addr = 15'h0001; vid_req = 1'b1; vid_addr = 15'h0100;
    va = 0; ca = 0; vbefore = -1; cfirst = -1;
    for (int c = 0; c < 48; c++) begin
      if (c > 0) step;
      smp;
      if (cpu_ack) begin
        if (cfirst < 0) begin
          cfirst = c;
          vbefore = va;
        end
        ca++;
      end
      if (vid_ack) va++;
    end
`ifdef VRAM_ARB_STARVE_EN
    chk("starve_cpu_cycle", 32'(cfirst), 32'd35);
    chk("starve_vid_before", 32'(vbefore), 32'd8);
    chk("starve_vid_total", 32'(va), 32'd11);
    chk("starve_cpu_total", 32'(ca), 32'd1);
`else
    chk("strict_cpu_total", 32'(ca), 32'd0);
    chk("strict_vid_total", 32'(va), 32'd12);
`endif
    step;
    cpu_req = 1'b0; vid_req = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
